// File: rtl/data_memory_if.sv
// Line-granular request/response bus between the data cache (master) and backing memory (slave).
interface data_memory_if;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o;
  logic [255:0] data_o;

  modport master (
    output enable_i, write_i, addr_i, data_i,
    input  ack_o, data_o
  );

  modport slave (
    input  enable_i, write_i, addr_i, data_i,
    output ack_o, data_o
  );
endinterface

// File: rtl/data_memory.sv
// Backing line memory for the data cache: fixed-latency 256-bit line reads/writes with a one-cycle ack.
module data_memory #(
  parameter int unsigned LATENCY   = 10,
  parameter int unsigned MEM_DEPTH = 512,
  parameter int unsigned IDX_W     = 9
) (
  input  logic           clk_i,
  input  logic           rst_i,
  data_memory_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  state_e             state_q;
  logic [7:0]         cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               wr_q;
  logic [255:0]       wdata_q;
  logic               ack_q;
  logic [255:0]       rdata_q;
  logic               run_q;

  logic [255:0]       mem [MEM_DEPTH];

  logic [IDX_W-1:0]   req_idx;
  logic               accept;
  logic               access;
  logic [IDX_W-1:0]   acc_idx;
  logic               acc_wr;
  logic [255:0]       acc_wdata;
  logic               unused_addr;

  assign req_idx     = bus.addr_i[IDX_W+4:5];
  assign unused_addr = ^{bus.addr_i[31:IDX_W+5], bus.addr_i[4:0]};

  // run_q keeps the array write (which has no reset) from firing while reset is held.
  always_comb begin
    accept = (state_q == IDLE) && bus.enable_i && run_q;
    if (LATENCY == 1) begin
      access    = accept;
      acc_idx   = req_idx;
      acc_wr    = bus.write_i;
      acc_wdata = bus.data_i;
    end else begin
      access    = (state_q == BUSY) && (cnt_q == 8'd1);
      acc_idx   = idx_q;
      acc_wr    = wr_q;
      acc_wdata = wdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (access && acc_wr) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      ack_q <= 1'b0;
      if (access && !acc_wr) begin
        rdata_q <= mem[acc_idx];
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q   <= req_idx;
            wr_q    <= bus.write_i;
            wdata_q <= bus.data_i;
            if (LATENCY == 1) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
            end else begin
              cnt_q   <= 8'(LATENCY - 1);
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed checks of data_memory latency, read/write, back-to-back, input glitches, reset abort and index wrap.
module tb_data_memory;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] D1     = {8{32'hD1D1_0001}};
  localparam logic [255:0] D2     = {8{32'h0000_D2D2}};
  localparam logic [255:0] D5     = {8{32'h5555_0005}};
  localparam logic [255:0] D7     = {8{32'h7777_0007}};
  localparam logic [255:0] D8     = {8{32'h8888_0008}};
  localparam logic [255:0] D9     = {8{32'h9999_0009}};
  localparam logic [255:0] W1234  = 256'h1234;

  always #5 clk = ~clk;

  data_memory_if bus ();

  data_memory #(
    .LATENCY  (10),
    .MEM_DEPTH(512),
    .IDX_W    (9)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts edges until ack_o is seen high; 0 means it never came within the bound.
  task automatic wait_ack(input string tag, input int exp_k);
    int k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.ack_o === 1'b1) begin
        k = i;
        break;
      end
    end
    chk(tag, 256'(k), 256'(exp_k));
  endtask

  initial begin
    int ack_seen;
    int data_bad;

    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    dut.mem[3] = PAT_A5;
    dut.mem[4] = D2;
    dut.mem[5] = D5;
    dut.mem[7] = D7;
    dut.mem[8] = D8;

    // Reset then idle
    repeat (3) tick();
    chk("rst_ack", 256'(bus.ack_o), 256'(0));
    chk("rst_data", bus.data_o, '0);
    rst_n = 1'b1;
    ack_seen = 0;
    data_bad = 0;
    repeat (20) begin
      tick();
      if (bus.ack_o !== 1'b0) ack_seen++;
      if (bus.data_o !== '0) data_bad++;
    end
    chk("idle_ack", 256'(ack_seen), 256'(0));
    chk("idle_data", 256'(data_bad), 256'(0));

    // Read latency: idx 3
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b0;
    bus.addr_i   = 32'h60;
    tick();
    wait_ack("rd_lat", 9);
    chk("rd_data", bus.data_o, PAT_A5);
    bus.enable_i = 1'b0;
    tick();
    chk("rd_ack_fall", 256'(bus.ack_o), 256'(0));
    chk("rd_hold", bus.data_o, PAT_A5);

    // Write then read idx 32
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h0000_0400;
    bus.data_i   = W1234;
    tick();
    wait_ack("wr_lat", 9);
    chk("wr_keeps_data", bus.data_o, PAT_A5);
    bus.write_i = 1'b0;
    wait_ack("raw_gap", 11);
    chk("raw_data", bus.data_o, W1234);
    chk("raw_mem32", dut.mem[32], W1234);
    bus.enable_i = 1'b0;
    tick();

    // Write-back to idx 2 then refill from idx 4
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h40;
    bus.data_i   = D1;
    tick();
    wait_ack("wb_lat", 9);
    bus.write_i = 1'b0;
    bus.addr_i  = 32'h80;
    wait_ack("rf_lat", 11);
    chk("wb_mem2", dut.mem[2], D1);
    chk("rf_data", bus.data_o, D2);
    bus.enable_i = 1'b0;
    tick();

    // Input glitches while busy
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b0;
    bus.addr_i   = 32'hA0;
    tick();
    tick();
    tick();
    bus.addr_i   = 32'hE0;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b1;
    bus.data_i   = D9;
    wait_ack("gl_lat", 7);
    chk("gl_data", bus.data_o, D5);
    chk("gl_mem7", dut.mem[7], D7);
    tick();
    bus.write_i = 1'b0;

    // Reset in the middle of a write to idx 8
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h100;
    bus.data_i   = D9;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 256'(bus.ack_o), 256'(0));
    chk("mid_rst_data", bus.data_o, '0);
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ack_seen = 0;
    repeat (15) begin
      tick();
      if (bus.ack_o !== 1'b0) ack_seen++;
    end
    chk("mid_rst_noack", 256'(ack_seen), 256'(0));
    chk("mid_rst_mem8", dut.mem[8], D8);

    // Index wrap: 0x4060 -> idx 3
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b0;
    bus.addr_i   = 32'h4060;
    tick();
    wait_ack("wrap_lat", 9);
    chk("wrap_data", bus.data_o, PAT_A5);
    bus.enable_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
